// File: rtl/seg7_scan.sv
// seg7_scan: latches a 4-digit BCD value and multiplexes it onto a common-anode 7-segment display
module seg7_scan #(
  parameter int SCAN_DIV = 50000,
  parameter int GUARD = 500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] data_in,
  input  logic        load,
  input  logic [3:0]  dp_in,
  input  logic        blank_lz,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);
  localparam int PW = $clog2(SCAN_DIV);
  logic [15:0]   data_q, data_d;
  logic [3:0]    sdp_q, sdp_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [1:0]    idx_q, idx_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic [3:0]    nib, lz;
  logic          wrap, guard, blank;

  function automatic logic [6:0] decode(input logic [3:0] n);
    case (n)
      4'd0: decode = 7'b1000000;
      4'd1: decode = 7'b1111001;
      4'd2: decode = 7'b0100100;
      4'd3: decode = 7'b0110000;
      4'd4: decode = 7'b0011001;
      4'd5: decode = 7'b0010010;
      4'd6: decode = 7'b0000010;
      4'd7: decode = 7'b1111000;
      4'd8: decode = 7'b0000000;
      4'd9: decode = 7'b0010000;
      default: decode = 7'b0111111;
    endcase
  endfunction

  // lz[k]: digit k and every digit above it are zero; digit 0 is never blanked
  always_comb begin
    data_d = load ? data_in : data_q;
    sdp_d = load ? dp_in : sdp_q;
    wrap = presc_q == PW'(SCAN_DIV - 1);
    presc_d = wrap ? '0 : presc_q + PW'(1);
    idx_d = wrap ? idx_q + 2'd1 : idx_q;
    nib = data_q[{idx_q, 2'b00} +: 4];
    lz[3] = data_q[15:12] == 4'd0;
    lz[2] = lz[3] && data_q[11:8] == 4'd0;
    lz[1] = lz[2] && data_q[7:4] == 4'd0;
    lz[0] = 1'b0;
    blank = blank_lz && lz[idx_q];
    guard = presc_q < PW'(GUARD);
    an_d = guard ? 4'hF : ~(4'b0001 << idx_q);
    seg_d = (guard || blank) ? 7'h7F : decode(nib);
    dp_d = guard || !sdp_q[idx_q];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
      sdp_q <= '0;
      presc_q <= '0;
      idx_q <= '0;
      an_q <= 4'hF;
      seg_q <= 7'h7F;
      dp_q <= 1'b1;
    end else begin
      data_q <= data_d;
      sdp_q <= sdp_d;
      presc_q <= presc_d;
      idx_q <= idx_d;
      an_q <= an_d;
      seg_q <= seg_d;
      dp_q <= dp_d;
    end
  end

  assign an = an_q;
  assign seg = seg_q;
  assign dp = dp_q;
endmodule

// File: tb/tb_seg7_scan.sv
// tb_seg7_scan: scoreboard bench for seg7_scan with SCAN_DIV=8, GUARD=2
module tb_seg7_scan;
  logic clk = 0, rst = 1, load = 0, blank_lz = 0;
  logic [15:0] data_in = '0;
  logic [3:0] dp_in = '0;
  logic [3:0] an;
  logic [6:0] seg;
  logic dp;
  int errors = 0, checks = 0;
  logic [11:0] sb[$];
  int m_presc = 0, m_idx = 0;
  logic [15:0] m_data = '0;
  logic [3:0] m_dp = '0;
  logic [6:0] lut [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                           7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                           7'b0000000, 7'b0010000, 7'b0111111, 7'b0111111,
                           7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111};

  seg7_scan #(.SCAN_DIV(8), .GUARD(2)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .load(load), .dp_in(dp_in),
    .blank_lz(blank_lz), .an(an), .seg(seg), .dp(dp)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] expect_out();
    logic [3:0] a;
    logic [6:0] s;
    logic [15:0] hi;
    if (m_presc < 2) return 12'hFFF;
    a = 4'hF;
    a[m_idx] = 1'b0;
    hi = m_data >> (4 * m_idx);
    s = (blank_lz && m_idx != 0 && hi == 16'h0) ? 7'h7F : lut[hi[3:0]];
    return {a, s, ~m_dp[m_idx]};
  endfunction

  task automatic chk(input string tag, input logic [11:0] o, input logic [11:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed={an,seg,dp}=%b expected=%b", tag, o, e);
    end
  endtask

  task automatic model_reset();
    m_presc = 0;
    m_idx = 0;
    m_data = '0;
    m_dp = '0;
  endtask

  task automatic cyc();
    sb.push_back(expect_out());
    if (load) begin
      m_data = data_in;
      m_dp = dp_in;
    end
    if (m_presc == 7) begin
      m_presc = 0;
      m_idx = (m_idx + 1) % 4;
    end else m_presc++;
    @(posedge clk);
    #1;
    chk("scan", {an, seg, dp}, sb.pop_front());
  endtask

  task automatic seek(input int i, input int p);
    int n = 0;
    while (!(m_idx == i && m_presc == p) && n < 40) begin
      cyc();
      n++;
    end
    if (n >= 40) begin
      checks++;
      errors++;
      $error("FAIL seek_bound observed=%0d expected<40", n);
    end
  endtask

  task automatic show(input int i);
    seek(i, 4);
    cyc();
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("reset", {an, seg, dp}, 12'hFFF);
    @(posedge clk);
    #1;
    rst = 0;
    model_reset();
    repeat (3) cyc();
    chk("rst_d0", {an, seg, dp}, {4'b1110, 7'b1000000, 1'b1});
    repeat (8) cyc();
    chk("rst_d1", {an, seg, dp}, {4'b1101, 7'b1000000, 1'b1});
    repeat (24) cyc();
    chk("period", {an, seg, dp}, {4'b1110, 7'b1000000, 1'b1});
    data_in = 16'h1234; dp_in = 4'b0100; load = 1;
    cyc();
    load = 0;
    show(0); chk("cap_d0", {an, seg, dp}, {4'b1110, 7'b0011001, 1'b1});
    show(1); chk("cap_d1", {an, seg, dp}, {4'b1101, 7'b0110000, 1'b1});
    show(2); chk("cap_d2", {an, seg, dp}, {4'b1011, 7'b0100100, 1'b0});
    show(3); chk("cap_d3", {an, seg, dp}, {4'b0111, 7'b1111001, 1'b1});
    blank_lz = 1; data_in = 16'h0007; dp_in = 4'b0000; load = 1;
    cyc();
    load = 0;
    show(3); chk("lz7_d3", {an, seg, dp}, {4'b0111, 7'h7F, 1'b1});
    show(2); chk("lz7_d2", {an, seg, dp}, {4'b1011, 7'h7F, 1'b1});
    show(1); chk("lz7_d1", {an, seg, dp}, {4'b1101, 7'h7F, 1'b1});
    show(0); chk("lz7_d0", {an, seg, dp}, {4'b1110, 7'b1111000, 1'b1});
    data_in = 16'h0000; load = 1;
    cyc();
    load = 0;
    show(0); chk("lz0_d0", {an, seg, dp}, {4'b1110, 7'b1000000, 1'b1});
    show(1); chk("lz0_d1", {an, seg, dp}, {4'b1101, 7'h7F, 1'b1});
    data_in = 16'h0A05; load = 1;
    cyc();
    load = 0;
    show(1); chk("lza_d1", {an, seg, dp}, {4'b1101, 7'b1000000, 1'b1});
    show(2); chk("lza_d2", {an, seg, dp}, {4'b1011, 7'b0111111, 1'b1});
    show(3); chk("lza_d3", {an, seg, dp}, {4'b0111, 7'h7F, 1'b1});
    show(0); chk("lza_d0", {an, seg, dp}, {4'b1110, 7'b0010010, 1'b1});
    data_in = 16'h9999;
    repeat (64) cyc();
    show(0); chk("gate_d0", {an, seg, dp}, {4'b1110, 7'b0010010, 1'b1});
    seek(0, 4);
    data_in = 16'h0008; load = 1;
    cyc();
    load = 0;
    chk("mid_old", {an, seg, dp}, {4'b1110, 7'b0010010, 1'b1});
    cyc();
    chk("mid_new", {an, seg, dp}, {4'b1110, 7'b0000000, 1'b1});
    repeat (2) cyc();
    show(2);
    chk("pre_arst", {an, seg, dp}, {4'b1011, 7'h7F, 1'b1});
    #2;
    rst = 1;
    #1;
    chk("async_rst", {an, seg, dp}, 12'hFFF);
    model_reset();
    @(posedge clk);
    #1;
    rst = 0;
    blank_lz = 0;
    repeat (3) cyc();
    chk("post_rst", {an, seg, dp}, {4'b1110, 7'b1000000, 1'b1});
    repeat (8) cyc();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
